// File: rtl/draw_rect_drop_ctl.sv
// Position controller for a mouse-placed rectangle: tracks the mouse, drops under gravity on click.
// Latency: positions registered, 1 clk from mouse/frame_tick to xpos/ypos; falling/landed decoded from state.
// Backpressure: none; motion advances only on frame_tick. Optional bounce via DRAW_RECT_BOUNCE_EN.
module draw_rect_drop_ctl #(
    parameter int POS_W   = 12,
    parameter int VEL_W   = 6,
    parameter int FLOOR_Y = 100,
    parameter int GRAVITY = 1,
    parameter int VEL_MAX = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             mouse_left,
    input  logic [POS_W-1:0] mouse_xpos,
    input  logic [POS_W-1:0] mouse_ypos,
    output logic [POS_W-1:0] xpos,
    output logic [POS_W-1:0] ypos,
    output logic             falling,
    output logic             landed
);

    localparam logic [POS_W-1:0] LP_FLOOR   = POS_W'(FLOOR_Y);
    localparam logic [POS_W:0]   LP_FLOOR_W = (POS_W+1)'(FLOOR_Y);
    localparam logic [VEL_W:0]   LP_GRAV_W  = (VEL_W+1)'(GRAVITY);
    localparam logic [VEL_W:0]   LP_VMAX_W  = (VEL_W+1)'(VEL_MAX);

    typedef enum logic [1:0] {
        S_TRACK  = 2'd0,
        S_FALL   = 2'd1,
        S_LANDED = 2'd2,
        S_RISE   = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [POS_W-1:0] r_xpos, r_ypos, w_xpos_nxt, w_ypos_nxt;
    logic [VEL_W-1:0] r_vel, w_vel_nxt;

    // Falling step: velocity grows by gravity and saturates; new y is one bit wider so it cannot wrap.
    logic [VEL_W:0]   w_vsum;
    logic [VEL_W-1:0] w_vfall;
    logic [POS_W:0]   w_ysum;

    assign w_vsum  = {1'b0, r_vel} + LP_GRAV_W;
    assign w_vfall = (w_vsum > LP_VMAX_W) ? LP_VMAX_W[VEL_W-1:0] : w_vsum[VEL_W-1:0];
    assign w_ysum  = {1'b0, r_ypos} + {{(POS_W+1-VEL_W){1'b0}}, w_vfall};

`ifdef DRAW_RECT_BOUNCE_EN
    localparam logic [VEL_W-1:0] LP_GRAV = VEL_W'(GRAVITY);

    // Rebound speed is half the impact speed; rising decelerates and clamps both y and vel at 0.
    logic [VEL_W-1:0] w_bounce;
    logic [POS_W-1:0] w_vel_pos;
    logic [POS_W-1:0] w_yrise;
    logic [VEL_W-1:0] w_vrise;

    assign w_bounce  = w_vfall >> 1;
    assign w_vel_pos = {{(POS_W-VEL_W){1'b0}}, r_vel};
    assign w_yrise   = (r_ypos >= w_vel_pos) ? (r_ypos - w_vel_pos) : '0;
    assign w_vrise   = (r_vel >= LP_GRAV) ? (r_vel - LP_GRAV) : '0;
`endif

    // State, position and velocity registers; reset aborts any motion in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_TRACK;
            r_xpos  <= '0;
            r_ypos  <= '0;
            r_vel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_xpos  <= w_xpos_nxt;
            r_ypos  <= w_ypos_nxt;
            r_vel   <= w_vel_nxt;
        end
    end

    // Next-state and next-motion decode.
    always_comb begin
        w_state_nxt = r_state;
        w_xpos_nxt  = r_xpos;
        w_ypos_nxt  = r_ypos;
        w_vel_nxt   = r_vel;
        case (r_state)
            S_TRACK: begin
                if (!mouse_left) begin
                    w_xpos_nxt = mouse_xpos;
                    w_ypos_nxt = mouse_ypos;
                end else begin
                    w_vel_nxt = '0;
                    if (r_ypos >= LP_FLOOR) begin
                        w_ypos_nxt  = LP_FLOOR;
                        w_state_nxt = S_LANDED;
                    end else begin
                        w_state_nxt = S_FALL;
                    end
                end
            end
            S_FALL: begin
                if (frame_tick) begin
                    if (w_ysum < LP_FLOOR_W) begin
                        w_ypos_nxt = w_ysum[POS_W-1:0];
                        w_vel_nxt  = w_vfall;
                    end else begin
                        w_ypos_nxt = LP_FLOOR;
`ifdef DRAW_RECT_BOUNCE_EN
                        if (w_bounce == '0) begin
                            w_vel_nxt   = '0;
                            w_state_nxt = S_LANDED;
                        end else begin
                            w_vel_nxt   = w_bounce;
                            w_state_nxt = S_RISE;
                        end
`else
                        w_vel_nxt   = '0;
                        w_state_nxt = S_LANDED;
`endif
                    end
                end
            end
            S_LANDED: begin
                if (frame_tick && !mouse_left) begin
                    w_state_nxt = S_TRACK;
                end
            end
`ifdef DRAW_RECT_BOUNCE_EN
            S_RISE: begin
                if (frame_tick) begin
                    w_ypos_nxt = w_yrise;
                    w_vel_nxt  = w_vrise;
                    if (w_vrise == '0) begin
                        w_state_nxt = S_FALL;
                    end
                end
            end
`endif
            default: begin
                w_state_nxt = S_TRACK;
            end
        endcase
    end

    assign xpos    = r_xpos;
    assign ypos    = r_ypos;
    assign landed  = (r_state == S_LANDED);
`ifdef DRAW_RECT_BOUNCE_EN
    assign falling = (r_state == S_FALL) || (r_state == S_RISE);
`else
    assign falling = (r_state == S_FALL);
`endif

endmodule

// File: tb/tb_draw_rect_drop_ctl.sv
// Bench for draw_rect_drop_ctl: default-parameter DUT plus a VEL_MAX=4 DUT sharing the same inputs.
// A behavioural model predicts both DUTs every clock; directed literals pin the model.
// Honours DRAW_RECT_BOUNCE_EN the same way the design does.
module tb_draw_rect_drop_ctl;

    localparam int POS_W = 12;
    localparam int FLOOR = 100;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             frame_tick = 1'b0;
    logic             mouse_left = 1'b0;
    logic [POS_W-1:0] mouse_xpos = '0;
    logic [POS_W-1:0] mouse_ypos = '0;

    logic [POS_W-1:0] x0, y0, x1, y1;
    logic             f0, l0, f1, l1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    draw_rect_drop_ctl u_dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .mouse_left(mouse_left),
        .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .xpos(x0), .ypos(y0), .falling(f0), .landed(l0)
    );

    draw_rect_drop_ctl #(.VEL_MAX(4)) u_dut4 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .mouse_left(mouse_left),
        .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .xpos(x1), .ypos(y1), .falling(f1), .landed(l1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Behavioural model: one "body" per DUT, described as a physical object.
    typedef enum int {M_TRACK, M_FALL, M_LANDED, M_RISE} mode_t;
    mode_t m_mode[2];
    int    m_x[2], m_y[2], m_v[2];
    int    vmax[2] = '{31, 4};

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_mode[i] = M_TRACK; m_x[i] = 0; m_y[i] = 0; m_v[i] = 0;
            end else begin
                case (m_mode[i])
                    M_TRACK: begin
                        if (!mouse_left) begin
                            m_x[i] = int'(mouse_xpos); m_y[i] = int'(mouse_ypos);
                        end else begin
                            m_v[i] = 0;
                            if (m_y[i] >= FLOOR) begin m_y[i] = FLOOR; m_mode[i] = M_LANDED; end
                            else m_mode[i] = M_FALL;
                        end
                    end
                    M_FALL: if (frame_tick) begin
                        int nv, ny;
                        nv = (m_v[i] + 1 > vmax[i]) ? vmax[i] : m_v[i] + 1;
                        ny = m_y[i] + nv;
                        if (ny < FLOOR) begin m_y[i] = ny; m_v[i] = nv; end
                        else begin
                            m_y[i] = FLOOR;
`ifdef DRAW_RECT_BOUNCE_EN
                            m_v[i] = nv / 2;
                            m_mode[i] = (m_v[i] == 0) ? M_LANDED : M_RISE;
`else
                            m_v[i] = 0;
                            m_mode[i] = M_LANDED;
`endif
                        end
                    end
                    M_LANDED: if (frame_tick && !mouse_left) m_mode[i] = M_TRACK;
                    M_RISE: if (frame_tick) begin
                        m_y[i] = (m_y[i] > m_v[i]) ? m_y[i] - m_v[i] : 0;
                        m_v[i] = (m_v[i] > 1) ? m_v[i] - 1 : 0;
                        if (m_v[i] == 0) m_mode[i] = M_FALL;
                    end
                    default: m_mode[i] = M_TRACK;
                endcase
            end
        end
    end

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("m0_x", 32'(x0), 32'(m_x[0]));
            chk("m0_y", 32'(y0), 32'(m_y[0]));
            chk("m0_fall", 32'(f0), 32'(m_mode[0] == M_FALL || m_mode[0] == M_RISE));
            chk("m0_land", 32'(l0), 32'(m_mode[0] == M_LANDED));
            chk("m1_x", 32'(x1), 32'(m_x[1]));
            chk("m1_y", 32'(y1), 32'(m_y[1]));
            chk("m1_fall", 32'(f1), 32'(m_mode[1] == M_FALL || m_mode[1] == M_RISE));
            chk("m1_land", 32'(l1), 32'(m_mode[1] == M_LANDED));
        end
    end

    // One clock with optional frame_tick; returns just after the following falling edge.
    task automatic step(input logic tk);
        frame_tick = tk;
        @(posedge clk);
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    int seq0[10] = '{51, 53, 56, 60, 65, 71, 78, 86, 95, 100};
    int seq4[10] = '{51, 53, 56, 60, 64, 68, 72, 76, 80, 84};
`ifdef DRAW_RECT_BOUNCE_EN
    int rise[5]  = '{95, 91, 88, 86, 85};
`endif

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_x", 32'(x0), 0);
        chk("rst_y", 32'(y0), 0);
        chk("rst_fall", 32'(f0), 0);
        chk("rst_land", 32'(l0), 0);
        rst = 1'b0;

        // Tracking
        mouse_xpos = 200; mouse_ypos = 50;
        step(0);
        chk("trk_x", 32'(x0), 200);
        chk("trk_y", 32'(y0), 50);
        chk("trk_fall", 32'(f0), 0);

        // Drop from y=50; a tick on the press cycle causes no motion
        mouse_left = 1'b1;
        step(1);
        chk("press_y", 32'(y0), 50);
        chk("press_fall", 32'(f0), 1);
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk($sformatf("drop_y%0d", i), 32'(y0), 32'(seq0[i]));
            chk($sformatf("vmax4_y%0d", i), 32'(y1), 32'(seq4[i]));
            if (i == 4) begin
                step(0); step(0);
                chk("hold_y", 32'(y0), 65);
            end
        end
        chk("drop_x", 32'(x0), 200);
`ifdef DRAW_RECT_BOUNCE_EN
        chk("bounce_fall", 32'(f0), 1);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk($sformatf("rise_y%0d", i), 32'(y0), 32'(rise[i]));
        end
        for (int i = 0; i < 100 && !l0; i++) step(1);
        chk("bounce_land", 32'(l0), 1);
        chk("bounce_y", 32'(y0), FLOOR);
`else
        chk("drop_land", 32'(l0), 1);
        chk("drop_fall", 32'(f0), 0);
`endif

        // Re-arm: held button keeps it landed
        mouse_xpos = 10; mouse_ypos = 20;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("hold_land", 32'(l0), 1);
        end
        chk("hold_x", 32'(x0), 200);
        mouse_left = 1'b0;
        step(1);
        chk("rearm_land", 32'(l0), 0);
        step(0);
        chk("rearm_x", 32'(x0), 10);
        chk("rearm_y", 32'(y0), 20);

        // Press below the floor lands at once
        mouse_xpos = 30; mouse_ypos = 150;
        step(0);
        chk("deep_y0", 32'(y0), 150);
        mouse_left = 1'b1;
        step(0);
        chk("deep_y", 32'(y0), FLOOR);
        chk("deep_land", 32'(l0), 1);
        mouse_left = 1'b0;
        step(1);
        step(0);
        chk("deep_track_y", 32'(y0), 150);

        // Async reset mid-fall
        mouse_xpos = 200; mouse_ypos = 50;
        step(0);
        mouse_left = 1'b1;
        step(0);
        step(1); step(1); step(1);
        chk("mid_y", 32'(y0), 56);
        #2 rst = 1'b1;
        #1;
        chk("arst_x", 32'(x0), 0);
        chk("arst_y", 32'(y0), 0);
        chk("arst_fall", 32'(f0), 0);
        #1 rst = 1'b0;
        mouse_left = 1'b0;
        @(negedge clk);
        chk("post_rst_x", 32'(x0), 200);
        chk("post_rst_fall", 32'(f0), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
